// File: rtl/fep_hdr_strip_if.sv
// AXI4-Stream beat bundle used on both sides of fep_hdr_strip.
interface fep_hdr_strip_if #(
    parameter int DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/fep_hdr_strip.sv
// Checks the FEP header, votes the length copies, strips 12 bytes, realigns.
// Optional voted-vs-received length check: define FEP_STRIP_LEN_CHK_EN.
module fep_hdr_strip #(
    parameter int          DATA_WIDTH = 512,
    parameter int          HDR_BYTES  = 12,
    parameter logic [47:0] FEP_HEADER = 48'h1eadfeb5ac0d
) (
    input  logic            clk,
    input  logic            rst,
    fep_hdr_strip_if.slave  s_axis,
    fep_hdr_strip_if.master m_axis,
    output logic [31:0]     pkt_out_cnt,
    output logic [31:0]     hdr_drop_cnt,
    output logic [31:0]     tmr_fix_cnt,
    output logic [31:0]     len_err_cnt
);
    localparam int BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int HDR_BITS    = HDR_BYTES * 8;
    localparam int CARRY_BYTES = BEAT_BYTES - HDR_BYTES;
    localparam int CARRY_BITS  = CARRY_BYTES * 8;

    typedef enum logic [1:0] {HDR, BODY, FLUSH, DROP} state_t;

    state_t                 state;
    logic [CARRY_BITS-1:0]  carry;
    logic [CARRY_BYTES-1:0] carry_keep;
    logic                   out_free;
    logic                   accept;
    logic                   hdr_ok;
    logic                   short_last;
    logic                   tmr_diff;
    logic [15:0]            len_a;
    logic [15:0]            len_b;
    logic [15:0]            len_c;
    logic                   emit;
    logic                   nx_last;
    logic [DATA_WIDTH-1:0]  nx_raw;
    logic [BEAT_BYTES-1:0]  nx_keep;

    function automatic logic [DATA_WIDTH-1:0] keep_mask(
        input logic [DATA_WIDTH-1:0] d,
        input logic [BEAT_BYTES-1:0] k
    );
        for (int i = 0; i < BEAT_BYTES; i++)
            keep_mask[8*i +: 8] = d[8*i +: 8] & {8{k[i]}};
    endfunction

    assign out_free = !m_axis.tvalid || m_axis.tready;
    assign s_axis.tready = (state == DROP) ||
                           (out_free && (state == HDR || state == BODY));
    assign accept = s_axis.tvalid && s_axis.tready;
    assign hdr_ok = s_axis.tdata[95:48] == FEP_HEADER;
    // tkeep is contiguous-low: k <= HDR_BYTES exactly when this bit is clear
    assign short_last = s_axis.tlast && !s_axis.tkeep[HDR_BYTES];
    assign len_a = s_axis.tdata[15:0];
    assign len_b = s_axis.tdata[31:16];
    assign len_c = s_axis.tdata[47:32];
    assign tmr_diff = (len_a != len_b) || (len_b != len_c);

    always_comb begin
        emit    = 1'b0;
        nx_last = 1'b0;
        nx_raw  = '0;
        nx_keep = '0;
        unique case (state)
            HDR: if (accept && hdr_ok && s_axis.tlast && !short_last) begin
                emit    = 1'b1;
                nx_last = 1'b1;
                nx_raw  = {{HDR_BITS{1'b0}}, s_axis.tdata[DATA_WIDTH-1:HDR_BITS]};
                nx_keep = {{HDR_BYTES{1'b0}}, s_axis.tkeep[BEAT_BYTES-1:HDR_BYTES]};
            end
            BODY: if (accept) begin
                emit    = 1'b1;
                nx_last = short_last;
                nx_raw  = {s_axis.tdata[HDR_BITS-1:0], carry};
                nx_keep = short_last ?
                          {s_axis.tkeep[HDR_BYTES-1:0], {CARRY_BYTES{1'b1}}} : '1;
            end
            FLUSH: if (out_free) begin
                emit    = 1'b1;
                nx_last = 1'b1;
                nx_raw  = {{HDR_BITS{1'b0}}, carry};
                nx_keep = {{HDR_BYTES{1'b0}}, carry_keep};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= HDR;
            carry         <= '0;
            carry_keep    <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tkeep  <= '0;
            m_axis.tlast  <= 1'b0;
            pkt_out_cnt   <= '0;
            hdr_drop_cnt  <= '0;
            tmr_fix_cnt   <= '0;
        end else begin
            if (emit) begin
                m_axis.tvalid <= 1'b1;
                m_axis.tdata  <= keep_mask(nx_raw, nx_keep);
                m_axis.tkeep  <= nx_keep;
                m_axis.tlast  <= nx_last;
                if (nx_last)
                    pkt_out_cnt <= pkt_out_cnt + 32'd1;
            end else if (m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
            unique case (state)
                HDR: if (accept) begin
                    if (!hdr_ok || short_last) begin
                        hdr_drop_cnt <= hdr_drop_cnt + 32'd1;
                        state        <= s_axis.tlast ? HDR : DROP;
                    end else begin
                        if (tmr_diff)
                            tmr_fix_cnt <= tmr_fix_cnt + 32'd1;
                        if (!s_axis.tlast) begin
                            carry <= s_axis.tdata[DATA_WIDTH-1:HDR_BITS];
                            state <= BODY;
                        end
                    end
                end
                BODY: if (accept) begin
                    carry      <= s_axis.tdata[DATA_WIDTH-1:HDR_BITS];
                    carry_keep <= s_axis.tkeep[BEAT_BYTES-1:HDR_BYTES];
                    if (s_axis.tlast)
                        state <= short_last ? HDR : FLUSH;
                end
                FLUSH: if (out_free) state <= HDR;
                DROP: if (accept && s_axis.tlast) state <= HDR;
                default: state <= HDR;
            endcase
        end
    end

`ifdef FEP_STRIP_LEN_CHK_EN
    localparam int KW = $clog2(BEAT_BYTES + 1);

    logic [KW-1:0] k_now;
    logic [15:0]   len_v;
    logic [15:0]   v_hold;
    logic [15:0]   byte_cnt;
    logic [15:0]   byte_sum;

    always_comb begin
        k_now = '0;
        for (int i = 0; i < BEAT_BYTES; i++)
            k_now = k_now + KW'(s_axis.tkeep[i]);
    end

    assign len_v    = (len_a & len_b) | (len_b & len_c) | (len_a & len_c);
    assign byte_sum = (state == HDR ? 16'd0 : byte_cnt) + 16'(k_now);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt    <= '0;
            v_hold      <= '0;
            len_err_cnt <= '0;
        end else if (accept) begin
            if (state == HDR && hdr_ok && !short_last) begin
                if (s_axis.tlast) begin
                    if (byte_sum != len_v)
                        len_err_cnt <= len_err_cnt + 32'd1;
                end else begin
                    byte_cnt <= byte_sum;
                    v_hold   <= len_v;
                end
            end else if (state == BODY) begin
                byte_cnt <= byte_sum;
                if (s_axis.tlast && byte_sum != v_hold)
                    len_err_cnt <= len_err_cnt + 32'd1;
            end
        end
    end
`else
    assign len_err_cnt = 32'd0;
`endif

endmodule
